// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: next-PC select codes, fetch FSM states, PC step.
package cpu_types_pkg;

  // Next-PC source chosen by the EX/MEM stage.
  typedef enum logic [1:0] {
    PC_NEXT   = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JR     = 2'd3
  } pcselect_t;

  // Fetch-unit control states.
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    REDIR_PEND = 2'd1,
    HALTED     = 2'd2
  } fetch_state_t;

  // Sequential instruction stride in bytes.
  localparam logic [31:0] PC_STEP = 32'd4;

  // Word-align an address by clearing its two low bits.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of fetch-unit signals: fu is the block side, tb the driving side.
interface fetch_unit_if;
  import cpu_types_pkg::*;

  logic        ihit;
  logic [31:0] imemload;
  logic        pc_enable;
  pcselect_t   pc_select;
  logic [31:0] branch_addr;
  logic [31:0] jump_addr;
  logic [31:0] jr_addr;
  logic        halt;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        fetch_valid;
  logic [31:0] instr_out;
  logic [31:0] npc_out;

  modport fu (
    input  ihit, imemload, pc_enable, pc_select,
    input  branch_addr, jump_addr, jr_addr, halt,
    output imemREN, imemaddr, fetch_valid, instr_out, npc_out
  );

  modport tb (
    output ihit, imemload, pc_enable, pc_select,
    output branch_addr, jump_addr, jr_addr, halt,
    input  imemREN, imemaddr, fetch_valid, instr_out, npc_out
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues imem reads, hands the fetched
// word and pc+4 to IF/ID, and applies EX/MEM redirects. A redirect arriving
// while a fetch is outstanding is parked in r_redir_q until that fetch
// returns; the returning (stale) word is then dropped.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        pc_enable,
  input  pcselect_t   pc_select,
  input  logic [31:0] branch_addr,
  input  logic [31:0] jump_addr,
  input  logic [31:0] jr_addr,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic        fetch_valid,
  output logic [31:0] instr_out,
  output logic [31:0] npc_out
);

  logic [31:0]  r_pc;
  logic [31:0]  r_redir_q;
  fetch_state_t r_state;

  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_target;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_redir_nxt;
  fetch_state_t w_state_nxt;

  assign w_pc_plus4 = r_pc + PC_STEP;

  // Next-PC mux; every target is forced to a word boundary.
  always_comb begin
    // NOTE: combinational blocks assign a default before any branch so no
    // path leaves the signal unassigned and a latch is never inferred.
    w_target = w_pc_plus4;
    unique case (pc_select)
      PC_NEXT:   w_target = w_pc_plus4;
      PC_BRANCH: w_target = branch_addr;
      PC_JUMP:   w_target = jump_addr;
      PC_JR:     w_target = jr_addr;
      default:   w_target = w_pc_plus4;
    endcase
    w_target = word_align(w_target);
  end

  // Control FSM: next state, next PC, parked redirect and request outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_redir_nxt = r_redir_q;
    imemREN     = 1'b1;
    fetch_valid = 1'b0;

    unique case (r_state)
      RUN: begin
        fetch_valid = ihit;
        if (pc_enable) begin
          if (ihit) begin
            w_pc_nxt = w_target;
          end else if (pc_select != PC_NEXT) begin
            // Keep imemaddr stable for the outstanding fetch; take the
            // redirect once it returns.
            w_redir_nxt = w_target;
            w_state_nxt = REDIR_PEND;
          end
        end
      end
      REDIR_PEND: begin
        // The returning word belongs to the wrong path, so it is dropped.
        if (ihit) begin
          w_pc_nxt    = r_redir_q;
          w_state_nxt = RUN;
        end
      end
      HALTED: begin
        imemREN = 1'b0;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase

    // Halt wins over any redirect or returning fetch.
    if (halt) begin
      w_state_nxt = HALTED;
      w_pc_nxt    = r_pc;
      w_redir_nxt = r_redir_q;
    end

    // Nothing is handed to IF/ID while reset is asserted.
    if (!nRST) begin
      fetch_valid = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!nRST) begin
      r_pc      <= PC_INIT;
      r_redir_q <= '0;
      r_state   <= RUN;
    end else begin
      r_pc      <= w_pc_nxt;
      r_redir_q <= w_redir_nxt;
      r_state   <= w_state_nxt;
    end
  end

  assign imemaddr  = r_pc;
  assign instr_out = imemload;
  assign npc_out   = w_pc_plus4;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined datapath. It owns the PC, drives the instruction-memory request and supplies the fetched word and next-PC to the IF/ID latch. It applies redirects (branch, jump, jr) requested by the EX/MEM stage when the hazard unit allows it. A redirect that arrives while an instruction fetch is outstanding is held until that fetch completes; the stale instruction is then discarded.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded at reset.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- nRST  in  1  reset. Synchronous, active-low: sampled on the CLK rising edge.
- ihit  in  1  instruction memory returned imemload for imemaddr this cycle.
- imemload  in  32  instruction word from instruction memory.
- pc_enable  in  1  hazard-unit permission to advance or redirect the PC.
- pc_select  in  pcselect_t  next-PC source, one of PC_NEXT, PC_BRANCH, PC_JUMP, PC_JR.
- branch_addr  in  32  branch target from EX/MEM.
- jump_addr  in  32  jump target from EX/MEM.
- jr_addr  in  32  register target from EX/MEM.
- halt  in  1  HALT retired at MEM/WB.
- imemREN  out  1  instruction read request.
- imemaddr  out  32  fetch address; always equals pc.
- fetch_valid  out  1  instr_out and npc_out are valid for IF/ID this cycle.
- instr_out  out  32  fetched instruction; equals imemload.
- npc_out  out  32  pc + 4 of the fetched instruction.

## Operation
- The state machine type is fetch_state_t, with states RUN, REDIR_PEND and HALTED.
- Registers:
  - pc (32 bits)
  - redir_q (32 bits)
  - state
- Target selection:
  - PC_NEXT selects pc+4.
  - PC_BRANCH selects branch_addr.
  - PC_JUMP selects jump_addr.
  - PC_JR selects jr_addr.
  - Bits [1:0] of the selected target are forced to 00.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- RUN state:
  - imemREN=1.
  - pc_enable=1 and ihit=1: pc <= target; fetch_valid=1.
  - pc_enable=1, ihit=0, pc_select!=PC_NEXT: redir_q <= target; go to REDIR_PEND; pc is unchanged.
  - pc_enable=0: pc holds; fetch_valid=ihit.
- REDIR_PEND state:
  - imemREN=1 and imemaddr=pc, held stable until ihit.
  - On ihit: fetch_valid=0 (the stale word is dropped); pc <= redir_q; go to RUN.
  - Further redirects received in this state are ignored. The hazard unit holds EX/MEM until the redirect has been taken.
- HALTED state:
  - imemREN=0, fetch_valid=0, pc frozen.
  - Only reset leaves this state.
- halt=1 in any state: go to HALTED next cycle with no PC update. Halt takes priority over a simultaneous redirect and over ihit.
- Reset (nRST=0 at the edge) has the same effect in every state, including mid-fetch and in REDIR_PEND:
  - pc <= PC_INIT
  - redir_q <= 0
  - state <= RUN

## Timing
- Reset values:
  - pc=PC_INIT, so imemaddr=PC_INIT
  - imemREN=1
  - fetch_valid=0 while nRST=0
  - instr_out=imemload
  - npc_out=PC_INIT+4
- Outputs are combinational from the registers plus ihit and imemload. There is no output register; IF/ID provides the pipeline register.
- Fetch-to-IF/ID latency is 0 cycles: the word is presented in the cycle in which ihit is high.
- PC update latency is 1 edge after the qualifying ihit and pc_enable.
- imemaddr never changes while a request is outstanding, i.e. while imemREN=1 and ihit=0.
- A redirect pending in REDIR_PEND costs exactly one discarded fetch plus any wait cycles.

## Structure
- pcselect_t already exists in cpu_types_pkg.
- Add to cpu_types_pkg:
  - fetch_state_t
  - the constant PC_STEP=4
- Add fetch_unit_if.vh, with modports fu (block side) and tb (bench side).
- No sub-module; the next-PC mux stays inline.

## Test plan
- Reset with PC_INIT=0 and ihit held at 1: imemaddr steps 0, 4, 8, 12 on successive edges with fetch_valid=1. nRST=0 on the third edge returns imemaddr to 0.
- pc=0x40, pc_select=PC_BRANCH, branch_addr=0x103, ihit=1, pc_enable=1: next imemaddr=0x100.
- pc=0x40, PC_JUMP, jump_addr=0x200, ihit=0 for 3 cycles, then ihit=1:
  - imemaddr stays 0x40 throughout.
  - fetch_valid=0 on the ihit cycle.
  - The next imemaddr is 0x200 and the state is RUN.
- pc_enable=0 with ihit=1 for 2 cycles at pc=0x80: pc stays 0x80, fetch_valid=1 each cycle, npc_out=0x84.
- halt=1 in the same cycle as PC_JR with jr_addr=0x300 at pc=0x10: next cycle imemREN=0, pc=0x10, and the block stays halted until nRST=0.
- pc=32'hFFFF_FFFC, PC_NEXT, ihit=1: next imemaddr=0.
